demux16b6_buf: RTL
==================

Name: demux16b6_buf

Overview:
- Registered 1-to-6 demultiplexer for 16-bit datapath values; the write-side counterpart of the 6-input result mux.
- Steers one input word per cycle into one of six single-entry holding registers, chosen by a 3-bit select.
- Each holding register has its own valid/ack handshake to its consumer.
- Out-of-range selects (6, 7) are sunk and counted for debug.

Parameters:
- WIDTH, 16, data width of the input and of each holding register.
- CNT_WIDTH, 16, width of the saturating drop counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- in  input  WIDTH  data word to route.
- in_valid  input  1  producer has a word on in/select this cycle.
- select  input  3  destination channel 0-5; 6 and 7 are invalid.
- in_ready  output  1  combinational; word is accepted on the edge when in_valid && in_ready.
- out0..out5  output  WIDTH each  holding register contents per channel.
- out_valid  output  6  bit N set while channel N holds an unconsumed word.
- out_ack  input  6  bit N: consumer N takes its word this cycle; ignored when out_valid[N]=0.
- err  output  1  registered one-cycle pulse: an invalid-select word was accepted.
- drop_count  output  CNT_WIDTH  number of invalid-select words accepted; saturates.

Behaviour:
- Reset, asynchronous, active-high:
  - out0..out5 = 0, out_valid = 6'b0, err = 0, drop_count = 0.
  - Any word held at the reset edge is lost. No handshake completes during reset.
- Per-channel state: EMPTY (out_valid[N]=0) or FULL (out_valid[N]=1).
- in_ready:
  - select < 6: in_ready = !out_valid[select] || out_ack[select]. Same-cycle ack frees the slot (pass-through).
  - select >= 6: in_ready = 1; invalid words are always sunk.
  - in_ready depends only on select and channel state. It never depends on in_valid.
- Accept, valid select N, on the edge where in_valid && in_ready:
  - outN <= in, out_valid[N] <= 1.
  - Latency 1 cycle: the word is visible on outN and out_valid[N] the cycle after acceptance.
- Consume: on an edge where out_valid[N] && out_ack[N] and no accept targets N: out_valid[N] <= 0.
  - outN keeps its last value; it is stale, not cleared.
- Accept and ack to the same channel N on one edge: new word loads and out_valid[N] stays 1. No bubble, no loss.
- Accept to N and ack to M (M≠N) on the same edge: both take effect independently.
- Multiple acks on one edge are all honoured.
- Channels not addressed and not acked hold their state.
- Invalid select (6/7) with in_valid:
  - Accepted; no holding register changes.
  - err <= 1 for exactly the next cycle.
  - drop_count increments by 1, saturating at all-ones (16'hFFFF), no wrap.
  - err still pulses when the counter is saturated.
- in_valid = 0: no accept, err <= 0, and select is don't-care for all state.
- Back-to-back invalid selects: err stays high across consecutive cycles, and drop_count increments each cycle.
- Producer stall: if in_ready = 0 the producer holds in/select/in_valid. The block never drops a valid-select word.

Test Plan:
- Fill all channels: reset, then select=0..5 with in=1,3,7,15,31,63 on consecutive cycles, no acks. Required: out0..out5 = 1,3,7,15,31,63 and out_valid = 6'h3F. A seventh word to select=2 sees in_ready=0 and out2 stays 7.
- Pass-through: channel 2 FULL with 7. Drive in=99, select=2, in_valid=1 and out_ack[2]=1 on one cycle. Required: in_ready=1, next cycle out2=99 and out_valid[2]=1.
- Consume: ack channel 4 alone. Required: out_valid[4]=0 next cycle and out4 still 31. Then an accept to 4 of in=5 gives out4=5 and out_valid[4]=1.
- Invalid selects: select=6 then select=7 with in_valid=1, in=16'hBEEF. Required: in_ready=1 both cycles, err high for 2 cycles, drop_count=2, out0..out5 and out_valid unchanged.
- Saturation: preload or drive drop_count to 16'hFFFE, then send 3 invalid words. Required: drop_count=16'hFFFF and held, err pulses on every one.
- Mid-operation reset: out_valid=6'h3F, then assert reset asynchronously between edges. Required: immediately all outs 0, out_valid=0, err=0, drop_count=0. After release, the first accept of in=1, select=0 gives out0=1 one cycle later.

Source files
------------

// File: rtl/demux16b6_buf.sv
// Registered 1-to-6 demux: one word per cycle into six single-entry holding regs, visible 1 cycle after accept.
// in_ready drops only when the selected slot is full and not being acked this cycle; selects 6/7 are always sunk.
module demux16b6_buf #(
  parameter int WIDTH     = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     in,
  input  logic                 in_valid,
  input  logic [2:0]           select,
  output logic                 in_ready,
  output logic [WIDTH-1:0]     out0,
  output logic [WIDTH-1:0]     out1,
  output logic [WIDTH-1:0]     out2,
  output logic [WIDTH-1:0]     out3,
  output logic [WIDTH-1:0]     out4,
  output logic [WIDTH-1:0]     out5,
  output logic [5:0]           out_valid,
  input  logic [5:0]           out_ack,
  output logic                 err,
  output logic [CNT_WIDTH-1:0] drop_count
);

  logic [WIDTH-1:0]     data_q [6];
  logic [WIDTH-1:0]     data_d [6];
  logic [5:0]           valid_q, valid_d;
  logic                 err_q, err_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 sel_ok;
  logic                 slot_free;
  logic                 accept;

  // Ready is a function of select and slot state only; an ack in the same cycle frees the slot.
  always_comb begin
    sel_ok    = (select < 3'd6);
    slot_free = 1'b1;
    for (int n = 0; n < 6; n++) begin
      if (select == 3'(n)) slot_free = !valid_q[n] || out_ack[n];
    end
    in_ready = slot_free;
  end

  always_comb begin
    accept  = in_valid && in_ready;
    valid_d = valid_q & ~out_ack;
    for (int n = 0; n < 6; n++) begin
      data_d[n] = data_q[n];
      if (accept && sel_ok && (select == 3'(n))) begin
        data_d[n]  = in;
        valid_d[n] = 1'b1;
      end
    end
    err_d = accept && !sel_ok;
    cnt_d = cnt_q;
    if (err_d && (cnt_q != {CNT_WIDTH{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int n = 0; n < 6; n++) data_q[n] <= '0;
      valid_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      for (int n = 0; n < 6; n++) data_q[n] <= data_d[n];
      valid_q <= valid_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out0       = data_q[0];
  assign out1       = data_q[1];
  assign out2       = data_q[2];
  assign out3       = data_q[3];
  assign out4       = data_q[4];
  assign out5       = data_q[5];
  assign out_valid  = valid_q;
  assign err        = err_q;
  assign drop_count = cnt_q;

endmodule
